dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY_P, default 2, meaning cycles from request acceptance to memory access; legal range 1..15.
REQ-002 SHALL have parameter data_mem_addr_width_gp, default 12, meaning log2 of memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port from_core_i  input  $bits(mem_in_s)  core request: write_data, valid, wen, byte_not_word, and yumi (core accepts the response).
REQ-006 SHALL have port addr_i  input  data_mem_addr_width_gp+2  byte address of the request.
REQ-007 SHALL have port to_core_o  output  $bits(mem_out_s)  response: read_data, valid, and yumi (request accepted).

Function
REQ-008 SHALL hold 2^data_mem_addr_width_gp words of 32 bits, indexed by addr_i[data_mem_addr_width_gp+1:2].
REQ-009 SHALL implement the FSM states IDLE, BUSY and RESP, with one request outstanding at most.
REQ-010 In IDLE, SHALL drive to_core_o.yumi = from_core_i.valid combinationally; in BUSY and RESP it SHALL drive yumi 0.
REQ-011 On an IDLE edge with from_core_i.valid=1, SHALL latch addr_i, write_data, wen and byte_not_word, load the counter with LATENCY_P-1, and enter BUSY.
REQ-012 In BUSY, SHALL decrement the counter each edge; on the edge where the counter is 0, SHALL perform the memory access and enter RESP, so BUSY lasts exactly LATENCY_P cycles.
REQ-013 For a word write (wen=1, byte_not_word=0), SHALL write all 32 bits of write_data and ignore addr[1:0].
REQ-014 For a byte write, SHALL write write_data[7:0] into byte lane addr[1:0] (lane 0 = bits 7:0) and leave the other lanes unchanged.
REQ-015 For a word read, SHALL register the addressed 32-bit word into read_data.
REQ-016 For a byte read, SHALL register byte lane addr[1:0], zero-extended to 32 bits, into read_data.
REQ-017 For any write, SHALL register the full 32-bit word after the merge into read_data.
REQ-018 In RESP, SHALL hold to_core_o.valid=1 and read_data stable until an edge with from_core_i.yumi=1, then enter IDLE with valid=0.
REQ-019 to_core_o.valid SHALL be 0 in IDLE and BUSY.
REQ-020 Requests presented outside IDLE SHALL NOT be accepted and SHALL have no effect.
REQ-021 from_core_i.yumi SHALL be ignored outside RESP.
REQ-022 A new request may be accepted in the cycle immediately after the RESP→IDLE edge; a back-to-back request SHALL NOT be accepted in the RESP yumi cycle itself.
REQ-023 Timing: if a request is accepted in cycle T, valid SHALL first be high in cycle T+LATENCY_P+1.
REQ-024 Each memory access SHALL occur exactly once per accepted request, regardless of how long RESP is held.

Reset
REQ-025 While n_reset=0: state SHALL be IDLE, counter 0, to_core_o.valid=0, to_core_o.yumi=0, and read_data=0; this SHALL apply asynchronously.
REQ-026 Memory array contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted during BUSY SHALL abort the request, and a pending write SHALL NOT be performed.
REQ-028 Reset asserted during RESP SHALL drop the response.
REQ-029 After n_reset deasserts, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-030 Word write then read, LATENCY_P=2: write 0xDEADBEEF at addr 0x010 accepted in cycle 0 -> valid in cycle 3 with read_data=0xDEADBEEF; then a word read of 0x010 -> 0xDEADBEEF.
REQ-031 Byte merge: word 0x11223344 at 0x020, then a byte write of 0xAA at 0x022 -> write response 0x11AA3344; a byte read at 0x022 -> 0x000000AA; a byte read at 0x023 -> 0x00000011.
REQ-032 Backpressure: core holds from_core_i.yumi=0 for 5 cycles in RESP -> valid and read_data stay stable; a second request presented meanwhile gets yumi=0 and is never executed.
REQ-033 Reset mid-BUSY: start a word write of 0x12345678 to 0x040 (previously 0x0), pulse n_reset low in BUSY -> valid never rises, and a later read of 0x040 returns 0x0.
REQ-034 Latency sweep: LATENCY_P=1 and LATENCY_P=15 -> valid first high at T+2 and T+16 respectively.
REQ-035 Wrap/boundary: a word write to the highest word (addr 0x3FFC for width 12), then a read -> correct data, and word 0 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory that services one core request at a
// time. It accepts the request, waits a fixed number of cycles, performs the
// access, and then holds the response until the core accepts it.
//
// Ports
//   clk          - single clock; all state changes on its rising edge
//   n_reset      - asynchronous active-low reset (the memory array is not cleared)
//   from_core_i  - core request: write_data, valid, wen, byte_not_word, yumi
//   addr_i       - byte address of the request
//   to_core_o    - response: read_data, valid, yumi (request accepted)

package dmem_responder_pkg;
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;
endpackage

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY_P              = 2,   // legal range 1..15
  parameter int data_mem_addr_width_gp = 12
) (
  input  logic                              clk,
  input  logic                              n_reset,
  input  mem_in_s                           from_core_i,
  input  logic [data_mem_addr_width_gp+1:0] addr_i,
  output mem_out_s                          to_core_o
);

  localparam int AW    = data_mem_addr_width_gp;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wen_q, wen_d;
  logic             bnw_q, bnw_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0]      mem [2**AW];

  logic [AW-1:0]    wordIdx;
  logic [1:0]       lane;
  logic [31:0]      memWord;
  logic [31:0]      mergedWord;
  logic [7:0]       byteRead;
  logic             accessNow;

  assign wordIdx   = addr_q[AW+1:2];
  assign lane      = addr_q[1:0];
  assign memWord   = mem[wordIdx];
  assign accessNow = (state_q == BUSY) && (cnt_q == '0);

  // Word written back on a write: the whole write_data for word writes, or the
  // stored word with one byte lane replaced for byte writes.
  always_comb begin
    mergedWord = wdata_q;
    byteRead   = memWord[7:0];
    if (bnw_q) begin
      mergedWord = memWord;
      case (lane)
        2'd0: mergedWord[7:0]   = wdata_q[7:0];
        2'd1: mergedWord[15:8]  = wdata_q[7:0];
        2'd2: mergedWord[23:16] = wdata_q[7:0];
        default: mergedWord[31:24] = wdata_q[7:0];
      endcase
    end
    case (lane)
      2'd0: byteRead = memWord[7:0];
      2'd1: byteRead = memWord[15:8];
      2'd2: byteRead = memWord[23:16];
      default: byteRead = memWord[31:24];
    endcase
  end

  // Next-state and output logic. The access happens only on the single BUSY
  // edge where the counter reaches zero, so a long RESP never repeats it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    bnw_d   = bnw_q;
    rdata_d = rdata_q;

    to_core_o           = '0;
    to_core_o.read_data = rdata_q;

    case (state_q)
      IDLE: begin
        // Gated by n_reset so yumi stays low while reset is held.
        to_core_o.yumi = from_core_i.valid & n_reset;
        if (from_core_i.valid) begin
          addr_d  = addr_i;
          wdata_d = from_core_i.write_data;
          wen_d   = from_core_i.wen;
          bnw_d   = from_core_i.byte_not_word;
          cnt_d   = CNT_W'(LATENCY_P - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (wen_q) begin
            rdata_d = mergedWord;
          end else if (bnw_q) begin
            rdata_d = {24'b0, byteRead};
          end else begin
            rdata_d = memWord;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        to_core_o.valid = 1'b1;
        if (from_core_i.yumi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      bnw_q   <= bnw_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory contents survive reset; reset forces IDLE, so an aborted write
  // never reaches this port.
  always_ff @(posedge clk) begin
    if (accessNow && wen_q) begin
      mem[wordIdx] <= mergedWord;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. A LATENCY_P=2 instance
// runs a table of read/write vectors plus multi-cycle sequences (backpressure,
// reset in BUSY and RESP); LATENCY_P=1 and 15 instances check first-valid timing.

module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  mem_in_s     fc, fc1, fc15;
  logic [13:0] addr, addr1, addr15;
  mem_out_s    tc, tc1, tc15;

  dmem_responder #(.LATENCY_P(2), .data_mem_addr_width_gp(12)) dut (
    .clk(clk), .n_reset(n_reset), .from_core_i(fc), .addr_i(addr), .to_core_o(tc));

  dmem_responder #(.LATENCY_P(1), .data_mem_addr_width_gp(12)) dutL1 (
    .clk(clk), .n_reset(n_reset), .from_core_i(fc1), .addr_i(addr1), .to_core_o(tc1));

  dmem_responder #(.LATENCY_P(15), .data_mem_addr_width_gp(12)) dutL15 (
    .clk(clk), .n_reset(n_reset), .from_core_i(fc15), .addr_i(addr15), .to_core_o(tc15));

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        wen;
    logic        bnw;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present a request at a falling edge and check it is accepted immediately.
  task automatic applyStimulus(input string name, input logic wen, input logic bnw,
                               input logic [13:0] a, input logic [31:0] wd);
    fc.valid         = 1'b1;
    fc.wen           = wen;
    fc.byte_not_word = bnw;
    fc.write_data    = wd;
    addr             = a;
    #1;
    checkOutput({name, " yumi"}, 32'(tc.yumi), 32'd1);
  endtask

  // Accept a request, wait for valid, check latency and response data.
  task automatic startTxn(input string name, input logic wen, input logic bnw,
                          input logic [13:0] a, input logic [31:0] wd,
                          input logic [31:0] expData);
    int n;
    applyStimulus(name, wen, bnw, a, wd);
    @(posedge clk);
    @(negedge clk);
    fc.valid = 1'b0;
    fc.wen   = 1'b0;
    n = 1;
    while (!tc.valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " latency"}, 32'(n), 32'd3);
    checkOutput({name, " data"}, tc.read_data, expData);
  endtask

  task automatic finishTxn(input string name);
    fc.yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fc.yumi = 1'b0;
    checkOutput({name, " valid drop"}, 32'(tc.valid), 32'd0);
  endtask

  task automatic runTxn(input vec_t v);
    startTxn(v.name, v.wen, v.bnw, v.addr, v.wdata, v.expData);
    finishTxn(v.name);
  endtask

  initial begin
    int n1, n15;
    logic sawValid;

    vecs[0]  = '{1'b1, 1'b0, 14'h0010, 32'hDEADBEEF, 32'hDEADBEEF, "wr_word_010"};
    vecs[1]  = '{1'b0, 1'b0, 14'h0010, 32'hFFFFFFFF, 32'hDEADBEEF, "rd_word_010"};
    vecs[2]  = '{1'b1, 1'b0, 14'h0020, 32'h11223344, 32'h11223344, "wr_word_020"};
    vecs[3]  = '{1'b1, 1'b1, 14'h0022, 32'h000000AA, 32'h11AA3344, "wr_byte_022"};
    vecs[4]  = '{1'b0, 1'b1, 14'h0022, 32'hFFFFFFFF, 32'h000000AA, "rd_byte_022"};
    vecs[5]  = '{1'b0, 1'b1, 14'h0023, 32'h00000000, 32'h00000011, "rd_byte_023"};
    vecs[6]  = '{1'b0, 1'b1, 14'h0020, 32'h00000000, 32'h00000044, "rd_byte_020"};
    vecs[7]  = '{1'b1, 1'b1, 14'h0021, 32'hFFFFFF55, 32'h11AA5544, "wr_byte_021"};
    vecs[8]  = '{1'b1, 1'b0, 14'h0013, 32'hCAFEF00D, 32'hCAFEF00D, "wr_word_013"};
    vecs[9]  = '{1'b0, 1'b0, 14'h0010, 32'h00000000, 32'hCAFEF00D, "rd_word_010b"};
    vecs[10] = '{1'b1, 1'b0, 14'h0000, 32'h0BADF00D, 32'h0BADF00D, "wr_word_000"};
    vecs[11] = '{1'b1, 1'b0, 14'h3FFC, 32'h5A5AA5A5, 32'h5A5AA5A5, "wr_word_top"};
    vecs[12] = '{1'b0, 1'b0, 14'h3FFC, 32'h00000000, 32'h5A5AA5A5, "rd_word_top"};
    vecs[13] = '{1'b0, 1'b0, 14'h0000, 32'h00000000, 32'h0BADF00D, "rd_word_000"};
    vecs[14] = '{1'b1, 1'b0, 14'h0040, 32'h00000000, 32'h00000000, "wr_word_040"};
    vecs[15] = '{1'b0, 1'b1, 14'h3FFF, 32'h00000000, 32'h0000005A, "rd_byte_top"};

    fc = '0; fc1 = '0; fc15 = '0;
    addr = '0; addr1 = '0; addr15 = '0;

    // Reset with a request pending: nothing may be acknowledged.
    n_reset  = 1'b0;
    fc.valid = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset valid", 32'(tc.valid), 32'd0);
    checkOutput("reset yumi", 32'(tc.yumi), 32'd0);
    checkOutput("reset read_data", tc.read_data, 32'd0);
    fc.valid = 1'b0;
    n_reset  = 1'b1;

    // First vector is presented right away, so it lands on the first edge.
    foreach (vecs[i]) runTxn(vecs[i]);

    // Backpressure: hold RESP for 5 cycles while a write is presented.
    startTxn("bp_read", 1'b0, 1'b0, 14'h0020, 32'h0, 32'h11AA5544);
    fc.valid = 1'b1; fc.wen = 1'b1; fc.byte_not_word = 1'b0;
    fc.write_data = 32'hBAD0BAD0; addr = 14'h0020;
    #1;
    checkOutput("bp yumi", 32'(tc.yumi), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp hold valid", 32'(tc.valid), 32'd1);
      checkOutput("bp hold data", tc.read_data, 32'h11AA5544);
      checkOutput("bp hold yumi", 32'(tc.yumi), 32'd0);
    end
    fc.yumi = 1'b1;
    #1;
    checkOutput("bp yumi in ack cycle", 32'(tc.yumi), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp valid after ack", 32'(tc.valid), 32'd0);
    checkOutput("bp idle yumi", 32'(tc.yumi), 32'd1);
    fc.valid = 1'b0; fc.wen = 1'b0; fc.yumi = 1'b0;
    runTxn('{1'b0, 1'b0, 14'h0020, 32'h0, 32'h11AA5544, "bp_not_written"});

    // Reset in BUSY aborts a pending write.
    applyStimulus("rb_write", 1'b1, 1'b0, 14'h0040, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rb busy yumi", 32'(tc.yumi), 32'd0);
    fc.valid = 1'b0; fc.wen = 1'b0;
    n_reset = 1'b0;
    #1;
    checkOutput("rb valid in reset", 32'(tc.valid), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sawValid = sawValid | tc.valid;
    end
    checkOutput("rb valid never rises", 32'(sawValid), 32'd0);
    runTxn('{1'b0, 1'b0, 14'h0040, 32'h0, 32'h00000000, "rb_read_040"});
    runTxn('{1'b0, 1'b0, 14'h0010, 32'h0, 32'hCAFEF00D, "rb_mem_kept"});

    // Reset in RESP drops the response; next request accepted on first edge.
    startTxn("rr_read", 1'b0, 1'b0, 14'h0000, 32'h0, 32'h0BADF00D);
    n_reset = 1'b0;
    #1;
    checkOutput("rr valid dropped", 32'(tc.valid), 32'd0);
    checkOutput("rr read_data cleared", tc.read_data, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    runTxn('{1'b0, 1'b0, 14'h3FFC, 32'h0, 32'h5A5AA5A5, "rr_first_after"});

    // Latency sweep on the LATENCY_P=1 and LATENCY_P=15 instances.
    fc1.valid = 1'b1; fc1.wen = 1'b1; fc1.write_data = 32'h00000F0F; addr1 = 14'h0100;
    fc15.valid = 1'b1; fc15.wen = 1'b1; fc15.write_data = 32'h0000F0F0; addr15 = 14'h0104;
    @(posedge clk);
    @(negedge clk);
    fc1.valid = 1'b0; fc15.valid = 1'b0;
    n1 = 0; n15 = 0;
    for (int n = 1; n <= 40; n++) begin
      if (tc1.valid && n1 == 0) n1 = n;
      if (tc15.valid && n15 == 0) n15 = n;
      if (n1 != 0 && n15 != 0) break;
      @(negedge clk);
    end
    checkOutput("lat1 first valid", 32'(n1), 32'd2);
    checkOutput("lat15 first valid", 32'(n15), 32'd16);
    checkOutput("lat1 data", tc1.read_data, 32'h00000F0F);
    checkOutput("lat15 data", tc15.read_data, 32'h0000F0F0);
    fc1.yumi = 1'b1; fc15.yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fc1.yumi = 1'b0; fc15.yumi = 1'b0;
    checkOutput("lat1 valid drop", 32'(tc1.valid), 32'd0);
    checkOutput("lat15 valid drop", 32'(tc15.valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
